// File: rtl/adder.sv
// Registered unsigned add/subtract stage with carry/borrow, zero and signed-overflow flags.
// One cycle of latency, a new operation every cycle, and results that hold while i_valid is low.
module adder #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_valid,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             o_valid,
   output logic [WIDTH:0]   add_result,
   output logic             o_zero,
   output logic             o_overflow
);

   logic [WIDTH:0] sum_full;
   logic           ovf_calc;
   logic           zero_calc;

   logic           valid_d,    valid_q;
   logic [WIDTH:0] result_d,   result_q;
   logic           zero_d,     zero_q;
   logic           overflow_d, overflow_q;

   always_comb begin
      sum_full  = '0;
      ovf_calc  = 1'b0;
      zero_calc = 1'b0;
      if (i_sub) begin
         sum_full = {1'b0, op_a} - {1'b0, op_b};
         ovf_calc = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != op_a[WIDTH-1]);
      end else begin
         sum_full = {1'b0, op_a} + {1'b0, op_b};
         ovf_calc = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      // Carry/borrow bit is deliberately excluded from the zero flag.
      zero_calc = (sum_full[WIDTH-1:0] == '0);
   end

   always_comb begin
      valid_d    = i_valid;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      if (i_valid) begin
         result_d   = sum_full;
         zero_d     = zero_calc;
         overflow_d = ovf_calc;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         valid_q    <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
      end
   end

   assign o_valid    = valid_q;
   assign add_result = result_q;
   assign o_zero     = zero_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases, random traffic, hold and async reset.
// Expected values come from integer arithmetic on the operands, not from the RTL structure.
module tb_adder;
   localparam int W    = 8;
   localparam int MODW = 1 << W;
   localparam int MODR = 1 << (W + 1);

   logic          i_clk;
   logic          i_resetn;
   logic          i_valid;
   logic          i_sub;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          o_valid;
   logic [W:0]    add_result;
   logic          o_zero;
   logic          o_overflow;

   int n_tests;
   int n_fail;

   int exp_valid;
   int exp_res;
   int exp_zero;
   int exp_ovf;

   adder #(.WIDTH(W)) dut (
      .i_clk      (i_clk),
      .i_resetn   (i_resetn),
      .i_valid    (i_valid),
      .i_sub      (i_sub),
      .op_a       (op_a),
      .op_b       (op_b),
      .o_valid    (o_valid),
      .add_result (add_result),
      .o_zero     (o_zero),
      .o_overflow (o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= MODW / 2) ? v - MODW : v;
   endfunction

   task automatic model_reset();
      exp_valid = 0;
      exp_res   = 0;
      exp_zero  = 0;
      exp_ovf   = 0;
   endtask

   task automatic model_clock(input int valid, input int sub, input int a, input int b);
      int r;
      int sr;
      exp_valid = valid;
      if (valid != 0) begin
         r  = (sub != 0) ? a - b : a + b;
         sr = (sub != 0) ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
         exp_res  = ((r % MODR) + MODR) % MODR;
         exp_zero = ((exp_res % MODW) == 0) ? 1 : 0;
         exp_ovf  = (sr < -(MODW / 2) || sr > (MODW / 2) - 1) ? 1 : 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, {31'd0, o_valid},     exp_valid);
      chk({tag, ".res"},   {23'd0, add_result},  exp_res);
      chk({tag, ".zero"},  {31'd0, o_zero},      exp_zero);
      chk({tag, ".ovf"},   {31'd0, o_overflow},  exp_ovf);
   endtask

   // Drive one cycle of inputs, let the edge pass, then compare against the model.
   task automatic step(input string tag, input int valid, input int sub, input int a, input int b);
      i_valid = valid[0];
      i_sub   = sub[0];
      op_a    = a[W-1:0];
      op_b    = b[W-1:0];
      @(posedge i_clk);
      #1;
      if (i_resetn) model_clock(valid, sub, a, b);
      else          model_reset();
      check_outputs(tag);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      i_resetn = 1'b0;
      i_valid  = 1'b0;
      i_sub    = 1'b0;
      op_a     = '0;
      op_b     = '0;
      model_reset();

      for (int i = 0; i < 2; i++)
         step("rst_hold", 1, int'($urandom_range(0, 1)), int'($urandom_range(0, MODW - 1)),
              int'($urandom_range(0, MODW - 1)));

      i_resetn = 1'b1;
      step("rst_release", 0, 0, 8'hAA, 8'h55);
      step("rst_idle", 0, 1, 8'hFF, 8'h01);

      step("add_nc",   1, 0, 8'h30, 8'h14);
      step("add_c",    1, 0, 8'hFC, 8'h04);
      step("add_ov",   1, 0, 8'h7F, 8'h01);
      step("add_ff",   1, 0, 8'hFF, 8'hFF);
      step("sub_pos",  1, 1, 8'h30, 8'h14);
      step("sub_brw",  1, 1, 8'h14, 8'h30);
      step("sub_ov",   1, 1, 8'h80, 8'h01);
      step("sub_zero", 1, 1, 8'h55, 8'h55);
      step("hold0",    0, 0, 8'h01, 8'h01);
      step("hold1",    0, 1, 8'h10, 8'h20);

      for (int i = 0; i < 4; i++)
         step("b2b", 1, i % 2, 8'h40 + i * 8'h21, 8'h13 * (i + 1));
      step("b2b_drop", 0, 0, 8'h00, 8'h00);
      step("b2b_hold", 0, 1, 8'hFF, 8'h00);

      for (int i = 0; i < 300; i++)
         step("rand", int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
              int'($urandom_range(0, MODW - 1)), int'($urandom_range(0, MODW - 1)));

      step("pre_rst", 1, 0, 8'hFC, 8'h04);
      #2;
      i_resetn = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(posedge i_clk);
      #1;
      check_outputs("async_rst_edge");
      i_resetn = 1'b1;
      step("post_rst_idle", 0, 0, 8'h12, 8'h34);
      step("post_rst_op",   1, 0, 8'h12, 8'h34);
      step("post_rst_sub",  1, 1, 8'h00, 8'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/adder.md
# adder

Registered, parameterizable unsigned add/subtract unit. It takes two WIDTH-bit operands and produces a (WIDTH+1)-bit result that includes the carry/borrow bit, plus status flags. It is a leaf arithmetic block intended to sit inside datapaths, with a valid-qualified single-cycle pipeline stage.

## Interface
- WIDTH, default 8: operand width in bits (minimum 2).
- i_clk  input  1  sole clock; all state updates on its rising edge.
- i_resetn  input  1  asynchronous, active-low reset.
- i_valid  input  1  operands and i_sub are valid this cycle.
- i_sub  input  1  0 = add, 1 = subtract (op_a - op_b).
- op_a  input  WIDTH  operand A, unsigned (also interpreted as two's complement for o_overflow).
- op_b  input  WIDTH  operand B, same interpretation.
- o_valid  output  1  add_result and flags are valid.
- add_result  output  WIDTH+1  result; bit WIDTH = carry (add) or borrow (sub).
- o_zero  output  1  add_result[WIDTH-1:0] == 0.
- o_overflow  output  1  signed two's-complement overflow of the WIDTH-bit result.

## Operation
- Add: add_result = {1'b0,op_a} + {1'b0,op_b}; the full WIDTH+1 bits are exact and never wrap.
- Subtract: add_result = ({1'b0,op_a} - {1'b0,op_b}) mod 2^(WIDTH+1); bit WIDTH = 1 iff op_a < op_b (borrow). The low WIDTH bits equal (op_a - op_b) mod 2^WIDTH.
- o_zero evaluates only the low WIDTH bits (0xFC+0x04 gives o_zero=1 with carry=1).
- o_overflow, add: op_a[MSB]==op_b[MSB] and the result's bit WIDTH-1 differs from them. Sub: op_a[MSB]!=op_b[MSB] and the result's bit WIDTH-1 differs from op_a[MSB].
- Result and flags are computed combinationally from the inputs and captured into output registers when i_valid=1.
- When i_valid=0: o_valid deasserts on the next edge, and add_result, o_zero and o_overflow hold their last captured values.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N, with o_valid=1.
- Full throughput: a new operation is accepted every cycle, with no backpressure.
- o_valid is a registered copy of i_valid.
- Reset (i_resetn=0) immediately, independent of the clock, forces:
  - o_valid=0
  - add_result=0
  - o_zero=0
  - o_overflow=0
- Reset mid-operation: an in-flight result is discarded. The first valid output after release comes from the first i_valid=1 sampled on or after the first rising edge with i_resetn=1.
- Outputs are purely registered, with no combinational input-to-output paths.

## Test plan
- Reset: hold i_resetn=0 for 2 cycles with random inputs -> o_valid=0, add_result=0, o_zero=0, o_overflow=0. Release -> outputs are unchanged until the first i_valid.
- Add without carry: op_a=0x30, op_b=0x14, i_sub=0, i_valid=1 -> after 1 edge: add_result=0x044, o_valid=1, o_zero=0, o_overflow=0.
- Add with carry: op_a=0xFC, op_b=0x04 -> add_result=0x100, o_zero=1, o_overflow=0. Then 0x7F+0x01 -> 0x080, o_overflow=1. Then 0xFF+0xFF -> 0x1FE, o_overflow=0.
- Subtract: 0x30-0x14 -> 0x01C, o_overflow=0. Then 0x14-0x30 -> 0x1E4 (borrow set). Then 0x80-0x01 -> 0x07F, o_overflow=1. Then 0x55-0x55 -> 0x000, o_zero=1.
- Throughput/hold: issue 4 back-to-back valid operations followed by i_valid=0 -> 4 consecutive results in order, 1 cycle late. o_valid then drops, and add_result holds the last value.
- Async reset mid-stream: assert i_resetn=0 between clock edges while o_valid=1 -> outputs clear immediately, before the next edge.
